// File: rtl/result_pkg.sv
// Shared constants and FSM state type for the result register file and its
// streaming consumer.
package result_pkg;

  localparam int NUM_RESULTS    = 10;
  localparam int DATA_WIDTH     = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SEND,
    CLEAR,
    DONE
  } state_t;

endpackage

// File: rtl/result_byte_shifter.sv
// Holds one captured result word and presents it MSB byte first. The word is
// shifted left one byte each time the current byte is accepted.
module result_byte_shifter #(
  parameter int DATA_WIDTH = result_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  output logic [7:0]            byte_out
);

  logic [DATA_WIDTH-1:0] shift_q;

  // Capture a fresh word, or drop the accepted top byte.
  // NOTE: the datapath register is reset too, so tx_data reads 0 out of reset
  // rather than X; sequential state is always written with <= so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
    end else if (shift) begin
      shift_q <= shift_q << 8;
    end
  end

  assign byte_out = shift_q[DATA_WIDTH-1 -: 8];

endmodule

// File: rtl/result_streamer.sv
// Walks the result register file and serialises every word MSB byte first
// onto a valid/ready byte stream, optionally clearing the file afterwards.
module result_streamer #(
  parameter int NUM_RESULTS = result_pkg::NUM_RESULTS,
  parameter int DATA_WIDTH  = result_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  clear_after,
  output logic [SEL_WIDTH-1:0]  rf_out_sel,
  input  logic [DATA_WIDTH-1:0] rf_out_data,
  output logic                  rf_clear,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  import result_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(NUM_RESULTS - 1);
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 clear_q, clear_d;
  logic                 last_byte;
  logic                 last_word;

  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign last_word = (idx_q == LAST_IDX);

  // FSM state, word index, byte counter and the latched clear request.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      clear_q    <= clear_d;
    end
  end

  // Next-state logic: one SEL cycle per word, then one SEND cycle per accepted byte.
  // NOTE: every signal gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    clear_d    = clear_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          clear_d = clear_after;
          state_d = SEL;
        end
      end
      SEL: begin
        byte_cnt_d = '0;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (last_byte) begin
            if (last_word) begin
              state_d = clear_q ? CLEAR : DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = SEL;
            end
          end
        end
      end
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The index only changes on entry to SEL, so it doubles as the held read select.
  assign rf_out_sel = idx_q;
  assign tx_valid   = (state_q == SEND);
  assign tx_last    = tx_valid && last_word && last_byte;
  assign rf_clear   = (state_q == CLEAR);
  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  result_byte_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (state_q == SEL),
    .load_data (rf_out_data),
    .shift     (tx_valid && tx_ready),
    .byte_out  (tx_data)
  );

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: register file model, byte-queue
// reference, randomized backpressure, abort and a 1-word/8-bit build.
module tb_result_streamer;

  localparam int NR = 10;
  localparam int NB = 4;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        clear_after;
  logic [3:0]  rf_out_sel;
  logic [31:0] rf_out_data;
  logic        rf_clear;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        busy;
  logic        done;

  logic        s_start;
  logic [3:0]  s_rf_out_sel;
  logic [7:0]  s_rf_out_data;
  logic        s_rf_clear;
  logic [7:0]  s_tx_data;
  logic        s_tx_valid;
  logic        s_tx_ready;
  logic        s_tx_last;
  logic        s_busy;
  logic        s_done;

  logic [31:0] rf_regs  [NR];
  logic [31:0] exp_regs [NR];

  int total = 0;
  int bad   = 0;

  always #5 tb_clk = ~tb_clk;

  assign rf_out_data   = (rf_out_sel < 4'(NR)) ? rf_regs[rf_out_sel] : 32'h0;
  assign s_rf_out_data = (s_rf_out_sel == 4'd0) ? 8'hA5 : 8'h00;

  result_streamer u_dut (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .start       (start),
    .clear_after (clear_after),
    .rf_out_sel  (rf_out_sel),
    .rf_out_data (rf_out_data),
    .rf_clear    (rf_clear),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .busy        (busy),
    .done        (done)
  );

  result_streamer #(
    .NUM_RESULTS (1),
    .DATA_WIDTH  (8),
    .SEL_WIDTH   (4)
  ) u_small (
    .clk         (tb_clk),
    .n_rst       (n_rst),
    .start       (s_start),
    .clear_after (1'b0),
    .rf_out_sel  (s_rf_out_sel),
    .rf_out_data (s_rf_out_data),
    .rf_clear    (s_rf_clear),
    .tx_data     (s_tx_data),
    .tx_valid    (s_tx_valid),
    .tx_ready    (s_tx_ready),
    .tx_last     (s_tx_last),
    .busy        (s_busy),
    .done        (s_done)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink readiness for cycle k: 0 always ready, 1 the 1,0,0,1 pattern, 2 random.
  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 1) || (k % 4 == 0);
      default: return ($urandom % 2) == 1;
    endcase
  endfunction

  task automatic load_regs(input int mode);
    for (int i = 0; i < NR; i++) begin
      rf_regs[i]  = (mode == 0) ? 32'h1000_0000 + 32'(i) : $urandom;
      exp_regs[i] = rf_regs[i];
    end
  endtask

  // One run: expected stream is every word of exp_regs, MSB byte first.
  // mid_start > 0 re-pulses start in that cycle; abort_cycle > 0 resets there.
  task automatic run_stream(input bit clr, input int rmode, input int mid_start,
                            input int abort_cycle, input int exp_cycles);
    logic [7:0] exp_q[$];
    logic [7:0] want;
    int         k         = 1;
    int         last_acc  = 0;
    int         clr_seen  = 0;
    int         clr_cycle = 0;
    bit         fin       = 1'b0;
    bit         hold      = 1'b0;
    logic [7:0] hold_data = '0;
    logic       hold_last = 1'b0;

    for (int i = 0; i < NR; i++)
      for (int b = NB - 1; b >= 0; b--)
        exp_q.push_back(exp_regs[i][8*b +: 8]);

    @(posedge tb_clk); #1;
    start       = 1'b1;
    clear_after = clr;
    @(posedge tb_clk); #1;
    start       = 1'b0;
    clear_after = ~clr;
    tx_ready    = ready_for(rmode, 1);

    while (!fin && k <= 2000) begin
      if (k == abort_cycle) n_rst = 1'b0;
      @(negedge tb_clk);
      if (k == abort_cycle) begin
        check("abort_tx_valid", tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_rf_clear", rf_clear, 0);
        check("abort_done", done, 0);
        check("abort_sel", rf_out_sel, 0);
        @(posedge tb_clk); #1;
        n_rst = 1'b1;
        fin   = 1'b1;
      end else begin
        if (hold) begin
          check("hold_valid", tx_valid, 1);
          check("hold_data", tx_data, hold_data);
          check("hold_last", tx_last, hold_last);
        end
        if (rf_clear) begin
          clr_seen++;
          clr_cycle = k;
          for (int i = 0; i < NR; i++) rf_regs[i] = '0;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", 1, 0);
          end else begin
            want = exp_q.pop_front();
            check("byte_data", tx_data, want);
            check("byte_last", tx_last, exp_q.size() == 0);
          end
          last_acc = k;
        end
        hold      = tx_valid && !tx_ready;
        hold_data = tx_data;
        hold_last = tx_last;
        if (done) begin
          check("bytes_left", exp_q.size(), 0);
          check("rf_clear_count", clr_seen, int'(clr));
          if (clr) begin
            check("clear_cycle", clr_cycle, last_acc + 1);
            for (int i = 0; i < NR; i++) exp_regs[i] = '0;
          end
          check("done_cycle", k, last_acc + 1 + int'(clr));
          check("done_busy", busy, 1);
          if (exp_cycles > 0) check("run_cycles", k, exp_cycles);
          fin = 1'b1;
        end
        @(posedge tb_clk); #1;
        start    = (k + 1 == mid_start);
        tx_ready = ready_for(rmode, k + 1);
        k++;
      end
    end

    if (!fin) begin
      check("run_timeout", 0, 1);
    end else begin
      repeat (3) begin
        @(negedge tb_clk);
        check("idle_after_run", {busy, done, rf_clear, tx_valid}, 0);
        @(posedge tb_clk); #1;
      end
    end
  endtask

  initial begin
    int s_bytes  = 0;
    int s_done_k = 0;

    n_rst       = 1'b0;
    start       = 1'b0;
    clear_after = 1'b0;
    tx_ready    = 1'b0;
    s_start     = 1'b0;
    s_tx_ready  = 1'b1;
    load_regs(0);

    repeat (2) @(posedge tb_clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rf_clear", rf_clear, 0);
    check("rst_sel", rf_out_sel, 0);
    n_rst = 1'b1;

    // Full-rate stream of 0x1000_0000+i: 51 cycles, no clear.
    run_stream(1'b0, 0, 0, 0, NR * (1 + NB) + 1);

    // Backpressure 1,0,0,1 with DEADBEEF in word 0.
    rf_regs[0]  = 32'hDEAD_BEEF;
    exp_regs[0] = 32'hDEAD_BEEF;
    run_stream(1'b0, 1, 0, 0, 0);

    // Second start during SEND of word 3 is ignored.
    run_stream(1'b0, 0, 18, 0, NR * (1 + NB) + 1);

    // Reset during word 5 byte 2, then a fresh run from word 0.
    run_stream(1'b0, 0, 0, 29, 0);
    run_stream(1'b0, 0, 0, 0, NR * (1 + NB) + 1);

    // Random contents with random readiness and random clear requests.
    for (int r = 0; r < 4; r++) begin
      load_regs(1);
      run_stream(1'($urandom % 2), 2, 0, 0, 0);
    end

    // Clear after run, then the re-read must return all zeros.
    load_regs(1);
    run_stream(1'b1, 0, 0, 0, NR * (1 + NB) + 2);
    run_stream(1'b0, 2, 0, 0, 0);

    // Single 8-bit word build.
    @(posedge tb_clk); #1;
    s_start = 1'b1;
    @(posedge tb_clk); #1;
    s_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge tb_clk);
      if (s_tx_valid) begin
        s_bytes++;
        check("small_byte", s_tx_data, 'hA5);
        check("small_last", s_tx_last, 1);
        check("small_valid_cycle", k, 2);
      end
      if (s_done && s_done_k == 0) s_done_k = k;
      @(posedge tb_clk); #1;
    end
    check("small_bytes", s_bytes, 1);
    check("small_done_cycle", s_done_k, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
